// File: rtl/pipe_block_fifo_pkg.sv
// Shared geometry helpers for the width-converting block FIFO: lane ratio,
// narrow-unit width, capacity in units, count widths and legality checks.
package pipe_fifo_pkg;

   localparam int MAX_RATIO = 16;

   typedef enum logic [1:0] {
      MODE_PLAIN,
      MODE_UPSIZE,
      MODE_DOWNSIZE
   } size_mode_t;

   function automatic int fifo_hi(input int wr_w, input int rd_w);
      return (wr_w > rd_w) ? wr_w : rd_w;
   endfunction

   function automatic int fifo_nw(input int wr_w, input int rd_w);
      return (wr_w < rd_w) ? wr_w : rd_w;
   endfunction

   function automatic int fifo_ratio(input int wr_w, input int rd_w);
      return fifo_hi(wr_w, rd_w) / fifo_nw(wr_w, rd_w);
   endfunction

   function automatic int fifo_units(input int depth_wr, input int wr_w, input int rd_w);
      return depth_wr * wr_w / fifo_nw(wr_w, rd_w);
   endfunction

   function automatic int wr_count_w(input int depth_wr);
      return $clog2(depth_wr) + 1;
   endfunction

   function automatic int rd_count_w(input int depth_wr, input int wr_w, input int rd_w);
      return $clog2(depth_wr * wr_w / rd_w) + 1;
   endfunction

   function automatic size_mode_t size_mode(input int wr_w, input int rd_w);
      if (wr_w < rd_w) return MODE_UPSIZE;
      if (wr_w > rd_w) return MODE_DOWNSIZE;
      return MODE_PLAIN;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit params_legal(input int wr_w, input int rd_w, input int depth_wr);
      int hi;
      int lo;
      hi = fifo_hi(wr_w, rd_w);
      lo = fifo_nw(wr_w, rd_w);
      if (lo < 1) return 1'b0;
      if ((hi % lo) != 0) return 1'b0;
      if (!is_pow2(hi / lo) || (hi / lo) > MAX_RATIO) return 1'b0;
      if (!is_pow2(depth_wr) || depth_wr < 2) return 1'b0;
      if (((depth_wr * wr_w) % rd_w) != 0) return 1'b0;
      if ((depth_wr * wr_w / hi) < 2) return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/pipe_block_fifo_if.sv
// Handshake/data bundle between a pipe endpoint (master) and the FIFO (slave).
interface pipe_block_fifo_if
   import pipe_fifo_pkg::*;
#(
   parameter int WR_W     = 32,
   parameter int RD_W     = 256,
   parameter int DEPTH_WR = 1024
) ();

   localparam int WCW = wr_count_w(DEPTH_WR);
   localparam int RCW = rd_count_w(DEPTH_WR, WR_W, RD_W);

   logic [WR_W-1:0] din;
   logic            wr_en;
   logic            rd_en;
   logic [RD_W-1:0] dout;
   logic            valid;
   logic            full;
   logic            empty;
   logic [WCW-1:0]  wr_data_count;
   logic [RCW-1:0]  rd_data_count;
   logic            wr_ready_blk;
   logic            rd_ready_blk;
   logic            overflow;
   logic            underflow;

   modport master (
      output din, wr_en, rd_en,
      input  dout, valid, full, empty, wr_data_count, rd_data_count,
             wr_ready_blk, rd_ready_blk, overflow, underflow
   );

   modport slave (
      input  din, wr_en, rd_en,
      output dout, valid, full, empty, wr_data_count, rd_data_count,
             wr_ready_blk, rd_ready_blk, overflow, underflow
   );

endinterface

// File: rtl/pipe_block_fifo_ram.sv
// Lane-organised storage: RATIO lanes of N_W bits per row, per-lane write
// enables and one registered full-row read port. The array itself has no reset.
module pipe_fifo_ram #(
   parameter int N_W   = 32,
   parameter int RATIO = 8,
   parameter int ROWS  = 128,
   localparam int RW    = $clog2(ROWS),
   localparam int ROW_W = N_W * RATIO
) (
   input  logic             okClk,
   input  logic             reset,
   input  logic [RW-1:0]    wr_row,
   input  logic [RATIO-1:0] wr_lane_en,
   input  logic [ROW_W-1:0] wr_data,
   input  logic             rd_en,
   input  logic [RW-1:0]    rd_row,
   output logic [ROW_W-1:0] rd_data
);

   logic [RATIO-1:0][N_W-1:0] mem [ROWS];

   // Write only the lanes whose enable is set; other lanes of the row keep their data.
   always_ff @(posedge okClk) begin
      for (int k = 0; k < RATIO; k++) begin
         if (wr_lane_en[k]) mem[wr_row][k] <= wr_data[k*N_W +: N_W];
      end
   end

   // Output register clears on reset so dout starts at zero; it holds between reads.
   always_ff @(posedge okClk or posedge reset) begin
      if (reset) rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_row];
   end

endmodule

// File: rtl/pipe_block_fifo.sv
// Single-clock FIFO with power-of-two width conversion. Occupancy is tracked
// in narrow units; full/empty/counts are registered, block flags lag the counts
// by one cycle, and writes are refused for RST_BUSY edges after reset release.
module pipe_block_fifo
   import pipe_fifo_pkg::*;
#(
   parameter int WR_W      = 32,
   parameter int RD_W      = 256,
   parameter int DEPTH_WR  = 1024,
   parameter int BLOCK_WR  = 128,
   parameter int BLOCK_RD  = 128,
   parameter bit MSB_FIRST = 1'b1,
   parameter int RST_BUSY  = 4
) (
   input logic               okClk,
   input logic               reset,
   pipe_block_fifo_if.slave  bus
);

   localparam int         RATIO = fifo_ratio(WR_W, RD_W);
   localparam int         N_W   = fifo_nw(WR_W, RD_W);
   localparam int         UNITS = fifo_units(DEPTH_WR, WR_W, RD_W);
   localparam int         ROW_W = RATIO * N_W;
   localparam int         ROWS  = UNITS / RATIO;
   localparam int         WU    = WR_W / N_W;
   localparam int         RU    = RD_W / N_W;
   localparam int         PW    = $clog2(UNITS);
   localparam int         LW    = $clog2(RATIO);
   localparam int         LSW   = (LW > 0) ? LW : 1;
   localparam int         RW    = PW - LW;
   localparam int         OW    = PW + 1;
   localparam int         WUL   = $clog2(WU);
   localparam int         RUL   = $clog2(RU);
   localparam int         WCW   = wr_count_w(DEPTH_WR);
   localparam int         RCW   = rd_count_w(DEPTH_WR, WR_W, RD_W);
   localparam int         BW    = (RST_BUSY > 0) ? $clog2(RST_BUSY + 1) : 1;
   localparam size_mode_t MODE  = size_mode(WR_W, RD_W);

   if (!params_legal(WR_W, RD_W, DEPTH_WR)) begin : g_illegal
      $error("pipe_block_fifo: illegal width/depth parameters");
   end

   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic [OW-1:0]    occ;
   logic [OW-1:0]    occ_next;
   logic [OW-1:0]    free_wr;
   logic [BW-1:0]    busy_cnt;
   logic [BW-1:0]    busy_next;
   logic             busy_now;
   logic             wr_acc;
   logic             rd_acc;
   logic             full_q;
   logic             empty_q;
   logic             full_next;
   logic             empty_next;
   logic [WCW-1:0]   wcnt_q;
   logic [RCW-1:0]   rcnt_q;
   logic             wblk_q;
   logic             rblk_q;
   logic             ovf_q;
   logic             unf_q;
   logic             valid_q;
   logic [RW-1:0]    wr_row;
   logic [RW-1:0]    rd_row;
   logic [RATIO-1:0] lane_en;
   logic [ROW_W-1:0] ram_wdata;
   logic [ROW_W-1:0] ram_rdata;

   // Position within a row -> physical lane; MSB_FIRST puts the earliest word on top.
   function automatic logic [LSW-1:0] phys_lane(input logic [LSW-1:0] pos);
      return MSB_FIRST ? (LSW'(RATIO - 1) - pos) : pos;
   endfunction

   // Acceptance, next occupancy and next flag values from the current registers.
   always_comb begin
      busy_now   = (busy_cnt != '0);
      wr_acc     = bus.wr_en && !full_q;
      rd_acc     = bus.rd_en && !empty_q;
      busy_next  = busy_now ? (busy_cnt - BW'(1)) : busy_cnt;
      occ_next   = occ + (wr_acc ? OW'(WU) : '0) - (rd_acc ? OW'(RU) : '0);
      full_next  = (busy_next != '0) || ((OW'(UNITS) - occ_next) < OW'(WU));
      empty_next = (occ_next < OW'(RU));
      free_wr    = (OW'(UNITS) - occ) >> WUL;
      wr_row     = RW'(wp >> LW);
      rd_row     = RW'(rp >> LW);
   end

   // Pointers, occupancy, busy window and the registered full/empty/counts.
   always_ff @(posedge okClk or posedge reset) begin
      if (reset) begin
         wp       <= '0;
         rp       <= '0;
         occ      <= '0;
         busy_cnt <= BW'(RST_BUSY);
         full_q   <= 1'b1;
         empty_q  <= 1'b1;
         wcnt_q   <= '0;
         rcnt_q   <= '0;
      end else begin
         if (wr_acc) wp <= wp + PW'(WU);
         if (rd_acc) rp <= rp + PW'(RU);
         occ      <= occ_next;
         busy_cnt <= busy_next;
         full_q   <= full_next;
         empty_q  <= empty_next;
         wcnt_q   <= WCW'(occ_next >> WUL);
         rcnt_q   <= RCW'(occ_next >> RUL);
      end
   end

   // Block-throttle flags one stage behind the counts, plus error pulses and valid.
   always_ff @(posedge okClk or posedge reset) begin
      if (reset) begin
         wblk_q  <= 1'b0;
         rblk_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         wblk_q  <= (int'(free_wr) >= BLOCK_WR);
         rblk_q  <= (int'(rcnt_q) >= BLOCK_RD);
         ovf_q   <= bus.wr_en && full_q && !busy_now;
         unf_q   <= bus.rd_en && empty_q;
         valid_q <= rd_acc;
      end
   end

   if (MODE == MODE_UPSIZE) begin : g_up
      logic [LSW-1:0] wr_pos;

      // Each narrow write lands in one lane; a read returns the whole row.
      always_comb begin
         wr_pos  = LSW'(wp & PW'(RATIO - 1));
         lane_en = '0;
         if (wr_acc) lane_en[phys_lane(wr_pos)] = 1'b1;
      end

      assign ram_wdata = {RATIO{bus.din}};
      assign bus.dout  = ram_rdata;
   end else begin : g_dn
      logic [LSW-1:0]  lane_q;
      logic [RD_W-1:0] dout_sel;

      assign lane_en   = {RATIO{wr_acc}};
      assign ram_wdata = bus.din;

      // Remember which lane the accepted read wants, aligned with the RAM register.
      always_ff @(posedge okClk or posedge reset) begin
         if (reset) lane_q <= '0;
         else if (rd_acc) lane_q <= phys_lane(LSW'(rp & PW'(RATIO - 1)));
      end

      // Pick the narrow lane out of the registered row.
      always_comb begin
         dout_sel = '0;
         for (int k = 0; k < RATIO; k++) begin
            if (lane_q == LSW'(k)) dout_sel = ram_rdata[k*N_W +: N_W];
         end
      end

      assign bus.dout = dout_sel;
   end

   pipe_fifo_ram #(
      .N_W   (N_W),
      .RATIO (RATIO),
      .ROWS  (ROWS)
   ) u_ram (
      .okClk      (okClk),
      .reset      (reset),
      .wr_row     (wr_row),
      .wr_lane_en (lane_en),
      .wr_data    (ram_wdata),
      .rd_en      (rd_acc),
      .rd_row     (rd_row),
      .rd_data    (ram_rdata)
   );

   assign bus.valid         = valid_q;
   assign bus.full          = full_q;
   assign bus.empty         = empty_q;
   assign bus.wr_data_count = wcnt_q;
   assign bus.rd_data_count = rcnt_q;
   assign bus.wr_ready_blk  = wblk_q;
   assign bus.rd_ready_blk  = rblk_q;
   assign bus.overflow      = ovf_q;
   assign bus.underflow     = unf_q;

endmodule

// File: tb/tb_pipe_block_fifo.sv
// Directed bench: a 32->256 upsizing instance and a 64->32 downsizing instance
// share clock and reset; a vector table covers the downsizer, hand sequences
// cover fill/overflow, block flags, read-at-full and reset mid-fill.
module tb_pipe_block_fifo;

   logic okClk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   pipe_block_fifo_if #(.WR_W(32), .RD_W(256), .DEPTH_WR(1024)) bus_up ();
   pipe_block_fifo_if #(.WR_W(64), .RD_W(32),  .DEPTH_WR(128))  bus_dn ();

   pipe_block_fifo #(
      .WR_W(32), .RD_W(256), .DEPTH_WR(1024), .BLOCK_WR(128), .BLOCK_RD(128),
      .MSB_FIRST(1'b1), .RST_BUSY(4)
   ) u_up (
      .okClk (okClk),
      .reset (reset),
      .bus   (bus_up)
   );

   pipe_block_fifo #(
      .WR_W(64), .RD_W(32), .DEPTH_WR(128), .BLOCK_WR(16), .BLOCK_RD(128),
      .MSB_FIRST(1'b1), .RST_BUSY(4)
   ) u_dn (
      .okClk (okClk),
      .reset (reset),
      .bus   (bus_dn)
   );

   // Free-running clock.
   always #5 okClk = ~okClk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [63:0] din;
      logic        e_empty;
      logic        e_valid;
      logic        e_unf;
      int          e_wcnt;
      int          e_rcnt;
      logic        e_chk;
      logic [31:0] e_dout;
   } vec_t;

   vec_t vecs[12];

   task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge okClk);
      #1;
   endtask

   task automatic apply_stimulus(input logic wr, input logic rd, input logic [63:0] d);
      bus_dn.wr_en = wr;
      bus_dn.rd_en = rd;
      bus_dn.din   = d;
      step();
   endtask

   task automatic idle_all();
      bus_up.wr_en = 1'b0;
      bus_up.rd_en = 1'b0;
      bus_up.din   = '0;
      bus_dn.wr_en = 1'b0;
      bus_dn.rd_en = 1'b0;
      bus_dn.din   = '0;
   endtask

   task automatic do_reset();
      idle_all();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      repeat (4) step();
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0]  w[8];
      logic [255:0] exp_row;

      vecs[0]  = '{1'b0, 1'b1, 64'h0,                    1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 64'h11111111_22222222,    1'b0, 1'b0, 1'b0, 1, 2, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 1'b1, 64'h0,                    1'b0, 1'b1, 1'b0, 0, 1, 1'b1, 32'h11111111};
      vecs[3]  = '{1'b0, 1'b1, 64'h0,                    1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 32'h22222222};
      vecs[4]  = '{1'b0, 1'b0, 64'h0,                    1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 32'h22222222};
      vecs[5]  = '{1'b0, 1'b1, 64'h0,                    1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 32'h22222222};
      vecs[6]  = '{1'b1, 1'b0, 64'hAAAA0001_BBBB0002,    1'b0, 1'b0, 1'b0, 1, 2, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 1'b1, 64'hCCCC0003_DDDD0004,    1'b0, 1'b1, 1'b0, 1, 3, 1'b1, 32'hAAAA0001};
      vecs[8]  = '{1'b0, 1'b1, 64'h0,                    1'b0, 1'b1, 1'b0, 1, 2, 1'b1, 32'hBBBB0002};
      vecs[9]  = '{1'b0, 1'b1, 64'h0,                    1'b0, 1'b1, 1'b0, 0, 1, 1'b1, 32'hCCCC0003};
      vecs[10] = '{1'b0, 1'b1, 64'h0,                    1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 32'hDDDD0004};
      vecs[11] = '{1'b0, 1'b0, 64'h0,                    1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 32'hDDDD0004};

      idle_all();
      reset = 1'b1;
      step();
      step();

      // Reset values
      check_output("rst_full",  bus_up.full, 1);
      check_output("rst_empty", bus_up.empty, 1);
      check_output("rst_wcnt",  bus_up.wr_data_count, 0);
      check_output("rst_rcnt",  bus_up.rd_data_count, 0);
      check_output("rst_valid", bus_up.valid, 0);
      check_output("rst_dout",  bus_up.dout, 0);
      check_output("rst_wblk",  bus_up.wr_ready_blk, 0);
      check_output("rst_rblk",  bus_up.rd_ready_blk, 0);
      check_output("rst_ovf",   bus_up.overflow, 0);
      check_output("rst_unf",   bus_up.underflow, 0);
      check_output("rst_dn_full", bus_dn.full, 1);

      reset = 1'b0;
      repeat (4) step();
      check_output("busy_done_up_full", bus_up.full, 0);
      check_output("busy_done_dn_full", bus_dn.full, 0);

      // Downsizer vector table
      for (int i = 0; i < 12; i++) begin
         apply_stimulus(vecs[i].wr, vecs[i].rd, vecs[i].din);
         check_output($sformatf("dn_v%0d_empty", i), bus_dn.empty, vecs[i].e_empty);
         check_output($sformatf("dn_v%0d_full", i),  bus_dn.full, 0);
         check_output($sformatf("dn_v%0d_valid", i), bus_dn.valid, vecs[i].e_valid);
         check_output($sformatf("dn_v%0d_unf", i),   bus_dn.underflow, vecs[i].e_unf);
         check_output($sformatf("dn_v%0d_ovf", i),   bus_dn.overflow, 0);
         check_output($sformatf("dn_v%0d_wcnt", i),  bus_dn.wr_data_count, 256'(vecs[i].e_wcnt));
         check_output($sformatf("dn_v%0d_rcnt", i),  bus_dn.rd_data_count, 256'(vecs[i].e_rcnt));
         if (vecs[i].e_chk) check_output($sformatf("dn_v%0d_dout", i), bus_dn.dout, vecs[i].e_dout);
      end

      // Downsizer fill to 256 read words: rd_ready_blk trails rd_data_count by one edge
      for (int j = 1; j <= 128; j++) begin
         apply_stimulus(1'b1, 1'b0, {32'(j), 32'(j)});
         check_output($sformatf("dn_fill_rcnt_%0d", j), bus_dn.rd_data_count, 256'(2 * j));
         if (j == 64) check_output("dn_rblk_at_128", bus_dn.rd_ready_blk, 0);
         if (j == 65) check_output("dn_rblk_after_128", bus_dn.rd_ready_blk, 1);
      end
      check_output("dn_fill_full", bus_dn.full, 1);
      check_output("dn_fill_wcnt", bus_dn.wr_data_count, 128);
      apply_stimulus(1'b1, 1'b0, 64'h5);
      check_output("dn_fill_ovf", bus_dn.overflow, 1);
      check_output("dn_fill_rcnt_hold", bus_dn.rd_data_count, 256);
      apply_stimulus(1'b0, 1'b0, 64'h0);

      // Upsizer: eight words packed MSB-first into one 256-bit read
      do_reset();
      for (int i = 0; i < 8; i++) begin
         w[i] = 32'h000fffff - 32'(i) * 32'h00011111;
         exp_row[255 - 32*i -: 32] = w[i];
      end
      for (int i = 0; i < 8; i++) begin
         bus_up.wr_en = 1'b1;
         bus_up.din   = w[i];
         step();
         check_output($sformatf("up8_empty_%0d", i), bus_up.empty, (i < 7) ? 1 : 0);
      end
      check_output("up8_wcnt", bus_up.wr_data_count, 8);
      check_output("up8_rcnt", bus_up.rd_data_count, 1);
      bus_up.wr_en = 1'b0;
      bus_up.rd_en = 1'b1;
      step();
      bus_up.rd_en = 1'b0;
      check_output("up8_valid", bus_up.valid, 1);
      check_output("up8_dout_top", bus_up.dout[255:224], 32'h000fffff);
      check_output("up8_dout_bot", bus_up.dout[31:0], 32'h00088888);
      check_output("up8_dout", bus_up.dout, exp_row);
      check_output("up8_empty_after_read", bus_up.empty, 1);
      step();
      check_output("up8_valid_drop", bus_up.valid, 0);

      // Fill 1024 words with wr_en held; the 1025th write overflows
      for (int k = 1; k <= 1025; k++) begin
         bus_up.wr_en = 1'b1;
         bus_up.din   = 32'(k - 1);
         step();
         check_output($sformatf("fill_wcnt_%0d", k), bus_up.wr_data_count, 256'((k > 1024) ? 1024 : k));
         check_output($sformatf("fill_full_%0d", k), bus_up.full, (k >= 1024) ? 1 : 0);
         check_output($sformatf("fill_wblk_%0d", k), bus_up.wr_ready_blk, ((k - 1) <= 896) ? 1 : 0);
         check_output($sformatf("fill_ovf_%0d", k),  bus_up.overflow, (k == 1025) ? 1 : 0);
      end

      // Read and write together at full: read accepted, write refused
      for (int i = 0; i < 8; i++) exp_row[255 - 32*i -: 32] = 32'(i);
      bus_up.wr_en = 1'b1;
      bus_up.rd_en = 1'b1;
      bus_up.din   = 32'hDEAD0000;
      step();
      check_output("rwfull_wcnt",  bus_up.wr_data_count, 1016);
      check_output("rwfull_rcnt",  bus_up.rd_data_count, 127);
      check_output("rwfull_ovf",   bus_up.overflow, 1);
      check_output("rwfull_full",  bus_up.full, 0);
      check_output("rwfull_valid", bus_up.valid, 1);
      check_output("rwfull_dout",  bus_up.dout, exp_row);
      bus_up.rd_en = 1'b0;
      bus_up.din   = 32'h00000400;
      step();
      check_output("after_full_wcnt",  bus_up.wr_data_count, 1017);
      check_output("after_full_ovf",   bus_up.overflow, 0);
      check_output("after_full_valid", bus_up.valid, 0);
      bus_up.wr_en = 1'b0;
      step();
      check_output("after_full_ovf_idle", bus_up.overflow, 0);

      // Underflow on the upsizer
      do_reset();
      bus_up.rd_en = 1'b1;
      step();
      bus_up.rd_en = 1'b0;
      check_output("up_unf", bus_up.underflow, 1);
      check_output("up_unf_valid", bus_up.valid, 0);
      check_output("up_unf_dout", bus_up.dout, 0);
      step();
      check_output("up_unf_pulse_end", bus_up.underflow, 0);

      // Reset mid-fill at 500 words, after a read has loaded dout
      for (int k = 0; k < 500; k++) begin
         bus_up.wr_en = 1'b1;
         bus_up.din   = 32'(k);
         step();
      end
      check_output("mid_wcnt_500", bus_up.wr_data_count, 500);
      bus_up.rd_en = 1'b1;
      bus_up.din   = 32'(500);
      step();
      bus_up.rd_en = 1'b0;
      check_output("mid_valid", bus_up.valid, 1);
      check_output("mid_dout", bus_up.dout, exp_row);
      check_output("mid_wcnt_493", bus_up.wr_data_count, 493);
      @(posedge okClk);
      #3;
      reset = 1'b1;
      #1;
      check_output("mid_rst_full",  bus_up.full, 1);
      check_output("mid_rst_empty", bus_up.empty, 1);
      check_output("mid_rst_wcnt",  bus_up.wr_data_count, 0);
      check_output("mid_rst_rcnt",  bus_up.rd_data_count, 0);
      check_output("mid_rst_valid", bus_up.valid, 0);
      check_output("mid_rst_dout",  bus_up.dout, 0);
      check_output("mid_rst_wblk",  bus_up.wr_ready_blk, 0);
      check_output("mid_rst_rblk",  bus_up.rd_ready_blk, 0);
      check_output("mid_rst_ovf",   bus_up.overflow, 0);
      check_output("mid_rst_unf",   bus_up.underflow, 0);
      step();
      step();
      reset = 1'b0;
      check_output("busy_full_0", bus_up.full, 1);
      for (int e = 1; e <= 4; e++) begin
         step();
         check_output($sformatf("busy_full_%0d", e), bus_up.full, (e < 4) ? 1 : 0);
         check_output($sformatf("busy_ovf_%0d", e),  bus_up.overflow, 0);
         check_output($sformatf("busy_wcnt_%0d", e), bus_up.wr_data_count, 0);
      end
      step();
      check_output("busy_first_write", bus_up.wr_data_count, 1);
      bus_up.wr_en = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
